// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bit-counter width; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/FullAdder.sv
// Single-bit full-adder cell; the only arithmetic in the serial adder datapath.
module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a flop.
// Optional macro SERIAL_ADDER_OVF_EN adds the two's-complement overflow output ovf_o.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf_o,
`endif
  output logic             busy_o
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry_q, cout_q;
  logic             fa_sum, fa_cout;
  logic             accept, last_bit;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state == RUN);
  assign accept      = in_valid_i && in_ready_o;
  assign last_bit    = (cnt == LAST);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;

  FullAdder u_full_adder (
    .a_i    (a_sr[0]),
    .b_i    (b_sr[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (last_bit)    state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_sr    <= a_i;
      b_sr    <= b_i;
      carry_q <= cin_i;
      cnt     <= '0;
    end else if (state == RUN) begin
      // Sum register shifts right so the LSB computed first ends up in bit 0.
      sum_q   <= (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry_q <= fa_cout;
      if (last_bit) cout_q <= fa_cout;
      else          cnt    <= cnt + CW'(1);
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the last bit the carry flop holds the carry into the MSB.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                         ovf_q <= 1'b0;
    else if ((state == RUN) && last_bit) ovf_q <= carry_q ^ fa_cout;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8 plus a WIDTH=1 instance).
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             in_valid_i, out_ready_i, cin_i;
  logic [WIDTH-1:0] a_i, b_i;
  logic             in_ready_o, out_valid_o, cout_o, busy_o;
  logic [WIDTH-1:0] sum_o;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_o, ovf1;
`endif

  logic w1_in_valid, w1_cin, w1_a, w1_b;
  logic w1_in_ready, w1_out_valid, w1_sum, w1_cout, w1_busy;

  always #5 clk_i = ~clk_i;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf_o       (ovf_o),
`endif
    .busy_o      (busy_o)
  );

  serial_adder #(.WIDTH(1)) dut_w1 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (w1_in_valid),
    .in_ready_o  (w1_in_ready),
    .a_i         (w1_a),
    .b_i         (w1_b),
    .cin_i       (w1_cin),
    .out_valid_o (w1_out_valid),
    .out_ready_i (1'b1),
    .sum_o       (w1_sum),
    .cout_o      (w1_cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf_o       (ovf1),
`endif
    .busy_o      (w1_busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[9];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accepts one operand set and waits for the result; retires it if out_ready_i is high.
  task automatic run_add(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!in_ready_o && n < 50) begin tick(); n++; end
    check({tag, " in_ready"}, 32'(in_ready_o), 1);
    a_i = v.a; b_i = v.b; cin_i = v.cin; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0; a_i = 8'($urandom); b_i = 8'($urandom); cin_i = 1'($urandom);
    check({tag, " busy"}, 32'(busy_o), 1);
    n = 0;
    while (!out_valid_o && n < 50) begin tick(); n++; end
    check({tag, " latency"}, n, WIDTH);
    check({tag, " sum"}, 32'(sum_o), 32'(v.sum));
    check({tag, " cout"}, 32'(cout_o), 32'(v.cout));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, 32'(ovf_o), 32'(v.ovf));
`endif
    check({tag, " in_ready in DONE"}, 32'(in_ready_o), 0);
    if (out_ready_i) begin
      tick();
      check({tag, " out_valid drop"}, 32'(out_valid_o), 0);
      check({tag, " sum held"}, 32'(sum_o), 32'(v.sum));
    end
  endtask

  initial begin
    int   acc_cyc[3];
    int   n_acc, n_res, cyc;
    logic fire_in, fire_out;
    logic [2:0] w1_vec[3];
    logic [2:0] w1_exp[3];

    //                 a      b      cin   sum    cout  ovf
    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; cin_i = 1'b0;
    w1_in_valid = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    check("reset sum", 32'(sum_o), 0);
    check("reset cout", 32'(cout_o), 0);
    check("reset out_valid", 32'(out_valid_o), 0);
    check("reset busy", 32'(busy_o), 0);
    check("reset in_ready", 32'(in_ready_o), 1);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset ovf", 32'(ovf_o), 0);
`endif

    for (int i = 0; i < 9; i++) run_add(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold and new operands must be refused.
    out_ready_i = 1'b0;
    run_add(vecs[0], "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; a_i = 8'($urandom); b_i = 8'($urandom);
      tick();
      check("bp out_valid", 32'(out_valid_o), 1);
      check("bp sum", 32'(sum_o), 32'(vecs[0].sum));
      check("bp cout", 32'(cout_o), 32'(vecs[0].cout));
      check("bp in_ready", 32'(in_ready_o), 0);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    check("bp release out_valid", 32'(out_valid_o), 0);
    check("bp release in_ready", 32'(in_ready_o), 1);
    check("bp release busy", 32'(busy_o), 0);

    // Reset in the middle of RUN, just before bit 4 is processed.
    a_i = 8'h5A; b_i = 8'h33; cin_i = 1'b0; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (4) tick();
    check("midrun busy", 32'(busy_o), 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("midrun rst in_ready", 32'(in_ready_o), 1);
    check("midrun rst out_valid", 32'(out_valid_o), 0);
    check("midrun rst sum", 32'(sum_o), 0);
    check("midrun rst busy", 32'(busy_o), 0);
    run_add(vecs[8], "after_rst");

    // Back-to-back with in_valid_i held high.
    n_acc = 0; n_res = 0; cyc = 0;
    a_i = vecs[3].a; b_i = vecs[3].b; cin_i = vecs[3].cin; in_valid_i = 1'b1;
    while (n_res < 3 && cyc < 200) begin
      fire_in  = in_valid_i && in_ready_o;
      fire_out = out_valid_o && out_ready_i;
      if (fire_out) begin
        check($sformatf("b2b%0d sum", n_res), 32'(sum_o), 32'(vecs[3+n_res].sum));
        check($sformatf("b2b%0d cout", n_res), 32'(cout_o), 32'(vecs[3+n_res].cout));
        n_res++;
      end
      tick();
      cyc++;
      if (fire_in && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) begin
          a_i = vecs[3+n_acc].a; b_i = vecs[3+n_acc].b; cin_i = vecs[3+n_acc].cin;
        end else begin
          in_valid_i = 1'b0;
        end
      end
    end
    check("b2b results", n_res, 3);
    check("b2b accepts", n_acc, 3);
    check("b2b spacing01", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
    check("b2b spacing12", acc_cyc[2] - acc_cyc[1], WIDTH + 2);

    // WIDTH=1: {a,b,cin} -> {ovf,cout,sum}
    w1_vec[0] = 3'b111; w1_exp[0] = 3'b011;
    w1_vec[1] = 3'b100; w1_exp[1] = 3'b001;
    w1_vec[2] = 3'b001; w1_exp[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w1_%0d in_ready", i), 32'(w1_in_ready), 1);
      {w1_a, w1_b, w1_cin} = w1_vec[i];
      w1_in_valid = 1'b1;
      tick();
      w1_in_valid = 1'b0;
      check($sformatf("w1_%0d busy", i), 32'(w1_busy), 1);
      tick();
      check($sformatf("w1_%0d out_valid", i), 32'(w1_out_valid), 1);
      check($sformatf("w1_%0d sum", i), 32'(w1_sum), 32'(w1_exp[i][0]));
      check($sformatf("w1_%0d cout", i), 32'(w1_cout), 32'(w1_exp[i][1]));
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("w1_%0d ovf", i), 32'(ovf1), 32'(w1_exp[i][2]));
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
